pio_in_multi: RTL and testbench
===============================

PIO_IN_MULTI -- requirements
Module: pio_in_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels (1..16).
REQ-002 Parameter DATA_W, default 32, width of each channel (1..32).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flops per input bit (0..3; 0 = inputs already in clk domain).
REQ-004 Derived constant ADDR_W = clog2(NUM_CH+4); word addressing.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 address  input  ADDR_W  Avalon-MM slave word address.
REQ-008 read  input  1  Avalon read strobe.
REQ-009 write  input  1  Avalon write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  NUM_CH*DATA_W  channel k on bits [k*DATA_W +: DATA_W].
REQ-013 irq  output  1  level interrupt, registered.

Function
REQ-014 Register map: 0..NUM_CH-1 CHAN[k]; NUM_CH CTRL; NUM_CH+1 CHANGE; NUM_CH+2 MASK; NUM_CH+3 INFO.
REQ-015 Each in_port bit passes through SYNC_STAGES flops producing sync[k]; sync path latency exactly SYNC_STAGES cycles.
REQ-016 CTRL bit0 MODE: 0 = CHAN[k] reads live sync[k]; 1 = CHAN[k] reads snapshot register snap[k].
REQ-017 Writing CTRL with bit1=1 latches sync[k] into snap[k] for all k on the same clock edge (coherent capture); bit1 reads back 0.
REQ-018 prev[k] registers sync[k] every cycle; CHANGE[k] sets when prev[k] != sync[k].
REQ-019 CHANGE bits are sticky; writing 1 to bit k clears it; writing 0 has no effect.
REQ-020 Same-cycle set and W1C clear of a CHANGE bit: set wins.
REQ-021 MASK is R/W, NUM_CH bits; irq = |(CHANGE & MASK), registered, asserted one cycle after the flag becomes visible.
REQ-022 INFO read-only: [7:0]=NUM_CH, [15:8]=DATA_W, [17:16]=SYNC_STAGES, rest 0.
REQ-023 readdata updates every cycle from address (read strobe not required, matching existing PIO behaviour); latency 1 cycle; narrow fields zero-extended.
REQ-024 Read of a register in the same cycle as a write to it returns the pre-write value.
REQ-025 Unmapped addresses read 0; writes to unmapped, CHAN or INFO addresses are ignored.
REQ-026 Unused bits of CTRL, CHANGE, MASK read 0.
REQ-027 Snapshot request while MODE=0 still updates snap[k].

Reset
REQ-028 On reset: readdata=0, irq=0, CTRL=0, CHANGE=0, MASK=0, snap=0, sync and prev flops=0.
REQ-029 First cycle after reset release shall not set CHANGE unless sync actually differs from prev (nonzero input produces one legitimate change event).
REQ-030 Reset asserted mid-operation overrides any same-cycle write.

Structure
REQ-031 Shared package pio_in_pkg holds register offset constants (relative to NUM_CH), CTRL bit indices and INFO field positions.
REQ-032 One sub-module pio_in_sync (parametrised width and stages, synchronous reset) instantiated per channel.

Verification
REQ-033 NUM_CH=4, DATA_W=16, SYNC=2: drive ch2=0x1234, read CHAN[2] after 3 cycles -> 0x00001234.
REQ-034 MODE=1, snap, then change all inputs -> CHAN reads return pre-change values until next snap write.
REQ-035 MASK=0x4, toggle ch2 -> CHANGE=0x4, irq=1; write CHANGE=0x4 -> irq=0 two cycles later.
REQ-036 W1C of CHANGE bit 1 in same cycle as new ch1 change -> bit 1 remains 1.
REQ-037 Read INFO -> 0x00021004; read address NUM_CH+4 -> 0; write CHAN[0] -> no effect.
REQ-038 Assert reset mid-stream with CHANGE=0xF, MASK=0xF -> next cycle irq=0, all registers 0.

Source files
------------

// File: rtl/pio_in_pkg.sv
// rtl/pio_in_pkg.sv - register offsets, CTRL bits and INFO layout for the multi-channel PIO input block
package pio_in_pkg;

  // Register offsets relative to NUM_CH; CHAN[k] occupies words 0..NUM_CH-1
  localparam int REG_CTRL_OFS   = 0;
  localparam int REG_CHANGE_OFS = 1;
  localparam int REG_MASK_OFS   = 2;
  localparam int REG_INFO_OFS   = 3;

  // CTRL bit positions
  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_SNAP_BIT  = 1;

  // INFO field positions and widths
  localparam int INFO_NUM_CH_LSB = 0;
  localparam int INFO_NUM_CH_W   = 8;
  localparam int INFO_DATA_W_LSB = 8;
  localparam int INFO_DATA_W_W   = 8;
  localparam int INFO_SYNC_LSB   = 16;
  localparam int INFO_SYNC_W     = 2;

  // Builds the constant INFO word from the elaboration parameters
  function automatic logic [31:0] info_word(input int num_ch, input int data_w, input int sync_stages);
    logic [31:0] w;
    logic [31:0] nc;
    logic [31:0] dw;
    logic [31:0] ss;
    nc = num_ch;
    dw = data_w;
    ss = sync_stages;
    w = '0;
    w[INFO_NUM_CH_LSB +: INFO_NUM_CH_W] = nc[INFO_NUM_CH_W-1:0];
    w[INFO_DATA_W_LSB +: INFO_DATA_W_W] = dw[INFO_DATA_W_W-1:0];
    w[INFO_SYNC_LSB +: INFO_SYNC_W]     = ss[INFO_SYNC_W-1:0];
    return w;
  endfunction

endpackage

// File: rtl/pio_in_sync.sv
// rtl/pio_in_sync.sv - per-channel input synchroniser chain, zero to three flops deep
module pio_in_sync
  import pio_in_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    // Inputs already live in the clk domain; clk and reset are not needed here
    logic unused_bypass;
    assign unused_bypass = clk ^ reset;
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through STAGES flops; reset clears the whole chain
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[STAGES-1];
  end

endmodule

// File: rtl/pio_in_multi.sv
// rtl/pio_in_multi.sv - multi-channel parallel input port with snapshot, change flags and interrupt
module pio_in_multi
  import pio_in_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DATA_W      = 32,
  parameter int  SYNC_STAGES = 2,
  localparam int ADDR_W      = $clog2(NUM_CH + 4)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                     irq
);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(NUM_CH + REG_CTRL_OFS);
  localparam logic [ADDR_W-1:0] A_CHANGE = ADDR_W'(NUM_CH + REG_CHANGE_OFS);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(NUM_CH + REG_MASK_OFS);
  localparam logic [ADDR_W-1:0] A_INFO   = ADDR_W'(NUM_CH + REG_INFO_OFS);
  localparam logic [31:0]       INFO_WORD = info_word(NUM_CH, DATA_W, SYNC_STAGES);

  logic [DATA_W-1:0] sync_q [NUM_CH];
  logic [DATA_W-1:0] prev_q [NUM_CH];
  logic [DATA_W-1:0] snap_q [NUM_CH];

  logic              mode_q;
  logic [NUM_CH-1:0] change_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] change_set;
  logic [NUM_CH-1:0] change_clr;

  logic              wr_ctrl;
  logic              wr_change;
  logic              wr_mask;
  logic              snap_req;
  logic [31:0]       rd_data;

  // Readdata is driven from address every cycle, so the read strobe carries no information
  logic unused_bus;
  assign unused_bus = ^{read, writedata};

  assign wr_ctrl   = write && (address == A_CTRL);
  assign wr_change = write && (address == A_CHANGE);
  assign wr_mask   = write && (address == A_MASK);
  assign snap_req  = wr_ctrl && writedata[CTRL_SNAP_BIT];

  // A W1C write only touches the bits written as 1
  assign change_clr = wr_change ? writedata[NUM_CH-1:0] : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pio_in_sync #(
      .WIDTH  (DATA_W),
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in_port[k*DATA_W +: DATA_W]),
      .q     (sync_q[k])
    );

    // A channel has changed whenever its synchronised value differs from last cycle's
    assign change_set[k] = (prev_q[k] != sync_q[k]);
  end

  // Track last cycle's synchronised value and take coherent snapshots of all channels at once
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k] <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k] <= sync_q[k];
        if (snap_req) snap_q[k] <= sync_q[k];
      end
    end
  end

  // Control state: MODE, sticky change flags (a new change beats a same-cycle clear), mask and irq
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= 1'b0;
      change_q <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) mode_q <= writedata[CTRL_MODE_BIT];
      if (wr_mask) mask_q <= writedata[NUM_CH-1:0];
      change_q <= (change_q & ~change_clr) | change_set;
      irq      <= |(change_q & mask_q);
    end
  end

  // Read mux over the pre-write register values; unmapped words read 0
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (address == ADDR_W'(k)) rd_data = 32'(mode_q ? snap_q[k] : sync_q[k]);
    end
    case (address)
      A_CTRL:   rd_data[CTRL_MODE_BIT] = mode_q;
      A_CHANGE: rd_data = 32'(change_q);
      A_MASK:   rd_data = 32'(mask_q);
      A_INFO:   rd_data = INFO_WORD;
      default:  ;
    endcase
  end

  // Register the read data for a fixed one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_data;
  end

endmodule

// File: tb/tb_pio_in_multi.sv
// tb/tb_pio_in_multi.sv - scoreboard bench for pio_in_multi (4x16 sync=2 and 3x8 sync=0 instances)
module tb_pio_in_multi;

  localparam int NA = 4;
  localparam int DA = 16;
  localparam int NB = 3;
  localparam int DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [2:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic              read_a = 1'b0;
  logic              write_a = 1'b0;
  logic              read_b = 1'b0;
  logic              write_b = 1'b0;
  logic [31:0]       readdata_a;
  logic [31:0]       readdata_b;
  logic              irq_a;
  logic              irq_b;
  logic [NA*DA-1:0]  in_a = '0;
  logic [NB*DB-1:0]  in_b = '0;

  pio_in_multi #(.NUM_CH(NA), .DATA_W(DA), .SYNC_STAGES(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .read      (read_a),
    .write     (write_a),
    .writedata (writedata),
    .readdata  (readdata_a),
    .in_port   (in_a),
    .irq       (irq_a)
  );

  pio_in_multi #(.NUM_CH(NB), .DATA_W(DB), .SYNC_STAGES(0)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .read      (read_b),
    .write     (write_b),
    .writedata (writedata),
    .readdata  (readdata_b),
    .in_port   (in_b),
    .irq       (irq_b)
  );

  typedef struct {
    bit          dut;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic        flag_a = 1'b0;
  logic        flag_b = 1'b0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  // A read strobe marks the cycle whose registered readdata is the response
  always @(posedge clk) begin
    flag_a <= read_a;
    flag_b <= read_b;
  end

  // Monitor: pop the expected word and compare against whichever DUT answered
  always @(negedge clk) begin
    if (flag_a || flag_b) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: response with no expected entry");
      end else begin
        mon_e = sb.pop_front();
        mon_act = mon_e.dut ? readdata_b : readdata_a;
        if (mon_act !== mon_e.exp) begin
          bad++;
          $display("FAIL %s: got 0x%08h want 0x%08h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input bit b, input logic [2:0] a, input logic [31:0] exp, input string nm);
    exp_t e;
    e.dut = b;
    e.exp = exp;
    e.name = nm;
    sb.push_back(e);
    address = a;
    if (b) read_b = 1'b1;
    else   read_a = 1'b1;
    cyc();
    read_a = 1'b0;
    read_b = 1'b0;
  endtask

  task automatic wr(input bit b, input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    if (b) write_b = 1'b1;
    else   write_a = 1'b1;
    cyc();
    write_a = 1'b0;
    write_b = 1'b0;
  endtask

  // Simultaneous read and write of the same word on DUT A
  task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
    exp_t e;
    e.dut = 1'b0;
    e.exp = exp;
    e.name = nm;
    sb.push_back(e);
    address = a;
    writedata = d;
    read_a = 1'b1;
    write_a = 1'b1;
    cyc();
    read_a = 1'b0;
    write_a = 1'b0;
  endtask

  task automatic chk_irq(input bit b, input logic exp, input string nm);
    logic act;
    @(negedge clk);
    act = b ? irq_b : irq_a;
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: irq got %b want %b", nm, act, exp);
    end
  endtask

  task automatic set_a(input int k, input logic [15:0] v);
    in_a[k*DA +: DA] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // DUT A map: CHAN0..3=0..3 CTRL=4 CHANGE=5 MASK=6 INFO=7
  // DUT B map: CHAN0..2=0..2 CTRL=3 CHANGE=4 MASK=5 INFO=6, 7 unmapped
  initial begin
    cyc(3);
    chk_irq(0, 1'b0, "reset_irq");
    reset = 1'b0;
    cyc(2);
    rd(0, 3'd5, 32'h0, "rst_change");
    rd(0, 3'd6, 32'h0, "rst_mask");
    rd(0, 3'd4, 32'h0, "rst_ctrl");
    rd(0, 3'd2, 32'h0, "rst_chan2");

    // Live read through two sync stages
    set_a(2, 16'h1234);
    cyc(3);
    rd(0, 3'd2, 32'h0000_1234, "chan2_live");
    rd(0, 3'd5, 32'h4, "change_ch2");
    chk_irq(0, 1'b0, "irq_masked_off");
    wr(0, 3'd5, 32'hF);
    rd(0, 3'd5, 32'h0, "change_clr_all");

    // Masked change raises irq; W1C drops it two cycles after the write
    wr(0, 3'd6, 32'h4);
    set_a(2, 16'h4321);
    cyc(4);
    rd(0, 3'd5, 32'h4, "change_toggle");
    chk_irq(0, 1'b1, "irq_set");
    wr(0, 3'd5, 32'h4);
    chk_irq(0, 1'b1, "irq_hold_one_cycle");
    chk_irq(0, 1'b0, "irq_cleared");
    rd(0, 3'd5, 32'h0, "change_after_w1c");

    // New ch1 change lands on the same edge as its W1C: set wins
    set_a(1, 16'h1111);
    cyc(4);
    rd(0, 3'd5, 32'h2, "change_ch1_first");
    set_a(1, 16'h2222);
    cyc(2);
    wr(0, 3'd5, 32'h2);
    rd(0, 3'd5, 32'h2, "change_set_wins");
    chk_irq(0, 1'b0, "irq_unmasked_bit1");
    wr(0, 3'd5, 32'h0);
    rd(0, 3'd5, 32'h2, "w0_no_effect");
    wr(0, 3'd5, 32'h2);
    rd(0, 3'd5, 32'h0, "w1c_bit1");

    // Coherent snapshot holds until the next snap request
    set_a(0, 16'hA0A0);
    set_a(3, 16'h0F0F);
    cyc(3);
    wr(0, 3'd4, 32'h3);
    rd(0, 3'd4, 32'h1, "ctrl_snap_reads_0");
    set_a(0, 16'h5555);
    set_a(1, 16'h6666);
    set_a(2, 16'h7777);
    set_a(3, 16'h8888);
    cyc(3);
    rd(0, 3'd0, 32'h0000_A0A0, "snap_chan0");
    rd(0, 3'd1, 32'h0000_2222, "snap_chan1");
    rd(0, 3'd2, 32'h0000_4321, "snap_chan2");
    rd(0, 3'd3, 32'h0000_0F0F, "snap_chan3");
    wr(0, 3'd4, 32'h3);
    rd(0, 3'd0, 32'h0000_5555, "resnap_chan0");
    rd(0, 3'd3, 32'h0000_8888, "resnap_chan3");

    // Snap request in MODE=0 still captures
    wr(0, 3'd4, 32'h0);
    set_a(0, 16'h1357);
    cyc(3);
    wr(0, 3'd4, 32'h2);
    set_a(0, 16'h9999);
    cyc(3);
    rd(0, 3'd0, 32'h0000_9999, "chan0_live_mode0");
    wr(0, 3'd4, 32'h1);
    rd(0, 3'd0, 32'h0000_1357, "snap_taken_in_mode0");

    // INFO, ignored writes, read-during-write
    rd(0, 3'd7, 32'h0002_1004, "info");
    wr(0, 3'd0, 32'hDEAD);
    rd(0, 3'd0, 32'h0000_1357, "chan_write_ignored");
    wr(0, 3'd7, 32'h0);
    rd(0, 3'd7, 32'h0002_1004, "info_write_ignored");
    rw(3'd6, 32'hF, 32'h4, "mask_prewrite_value");
    rd(0, 3'd6, 32'hF, "mask_after_write");
    rd(0, 3'd5, 32'hF, "change_all");
    chk_irq(0, 1'b1, "irq_all");

    // Second instance: no sync stages, unmapped address, narrow fields
    rd(1, 3'd6, 32'h0000_0803, "b_info");
    rd(1, 3'd7, 32'h0, "b_unmapped");
    in_b[1*DB +: DB] = 8'hAB;
    rd(1, 3'd1, 32'h0000_00AB, "b_chan1_nosync");
    rd(1, 3'd4, 32'h2, "b_change");
    wr(1, 3'd5, 32'hFF);
    rd(1, 3'd5, 32'h7, "b_mask_unused_bits");
    wr(1, 3'd3, 32'hFFFF_FFFF);
    rd(1, 3'd3, 32'h1, "b_ctrl_unused_bits");
    rd(1, 3'd1, 32'h0000_00AB, "b_snap_chan1");
    wr(1, 3'd7, 32'hFFFF_FFFF);
    rd(1, 3'd7, 32'h0, "b_unmapped_after_write");
    chk_irq(1, 1'b1, "b_irq");

    // Reset mid-stream beats a same-cycle MASK write
    reset = 1'b1;
    address = 3'd6;
    writedata = 32'hA;
    write_a = 1'b1;
    cyc();
    write_a = 1'b0;
    chk_irq(0, 1'b0, "irq_after_reset");
    rd(0, 3'd6, 32'h0, "readdata_in_reset");
    in_a = '0;
    cyc(3);
    reset = 1'b0;
    cyc(2);
    rd(0, 3'd4, 32'h0, "post_rst_ctrl");
    rd(0, 3'd5, 32'h0, "post_rst_change");
    rd(0, 3'd6, 32'h0, "post_rst_mask");
    wr(0, 3'd4, 32'h1);
    rd(0, 3'd0, 32'h0, "post_rst_snap");
    chk_irq(0, 1'b0, "post_rst_irq");

    cyc(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
